// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver with per-channel OFF/ON/BLINK/PWM modes.
// All channels share one blink timebase and one PWM timebase so they stay phase-aligned.
`timescale 1ns/1ps
module led_pattern_gen #(
    parameter int CLK_FREQ_KHz = 50000,
    parameter int LED_FREQ_Hz  = 1,
    parameter int CHANNELS     = 4,
    parameter int PWM_BITS     = 8,
    parameter int PWM_FREQ_Hz  = 1000,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic                sync,
    output logic [CHANNELS-1:0] led,
    output logic                pwm_wrap
);

    localparam int HALF_PERIOD = (CLK_FREQ_KHz * 1000) / (LED_FREQ_Hz * 2);
    localparam int STEP_DIV    = (CLK_FREQ_KHz * 1000) / (PWM_FREQ_Hz * (2 ** PWM_BITS));
    localparam int BC_W        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int SC_W        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(HALF_PERIOD - 1);
    localparam logic [SC_W-1:0] STEP_LAST  = SC_W'(STEP_DIV - 1);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    generate
        if (HALF_PERIOD < 1 || STEP_DIV < 1 || CHANNELS < 1 || CHANNELS > 32) begin : g_bad_params
            $error("led_pattern_gen: HALF_PERIOD and STEP_DIV must be >= 1, CHANNELS in 1..32");
        end
    endgenerate

    logic [BC_W-1:0]     blink_cnt_q;
    logic                blink_phase_q;
    logic [SC_W-1:0]     step_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_wrap_q;
    logic [CHANNELS-1:0] led_q;
    logic [CHANNELS-1:0] led_d;

    logic blink_last;
    logic step_tick;
    logic pwm_boundary;

    assign blink_last   = (blink_cnt_q == BLINK_LAST);
    assign step_tick    = (step_cnt_q == STEP_LAST);
    assign pwm_boundary = step_tick && (pwm_cnt_q == '1);

    // sync restarts both timebases and wins over any tick or wrap in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            step_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            pwm_wrap_q    <= 1'b0;
        end else begin
            if (blink_last) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            if (step_tick) begin
                step_cnt_q <= '0;
                pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            end else begin
                step_cnt_q <= step_cnt_q + 1'b1;
            end
            pwm_wrap_q <= pwm_boundary;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [1:0]          mode_q;
        logic [PWM_BITS-1:0] duty_pend_q;
        logic [PWM_BITS-1:0] duty_act_q;
        logic                wr_en;

        assign wr_en = cfg_we && (cfg_ch == CH_W'(gi));

        // duty_act samples the pre-write duty_pend, so a same-cycle write waits one boundary.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q      <= MODE_BLINK;
                duty_pend_q <= '0;
                duty_act_q  <= '0;
            end else begin
                if (wr_en) begin
                    mode_q      <= cfg_mode;
                    duty_pend_q <= cfg_duty;
                end
                if (sync || pwm_boundary) begin
                    duty_act_q <= duty_pend_q;
                end
            end
        end

        assign led_d[gi] = (mode_q == MODE_ON)
                         | ((mode_q == MODE_BLINK) & blink_phase_q)
                         | ((mode_q == MODE_PWM) & (pwm_cnt_q < duty_act_q))
                         | ((mode_q == MODE_OFF) & 1'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '1;
        end else begin
            led_q <= led_d;
        end
    end

    assign led      = led_q;
    assign pwm_wrap = pwm_wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (4 and 3 channels) against a cycle-count reference model.
`timescale 1ns/1ps
module tb_led_pattern_gen;

    localparam int CLK_KHZ = 1;
    localparam int LED_HZ  = 100;
    localparam int PWM_B   = 2;
    localparam int PWM_HZ  = 125;
    localparam int NCH     = 4;
    localparam int NCH_B   = 3;
    localparam int HP      = (CLK_KHZ * 1000) / (LED_HZ * 2);
    localparam int SD      = (CLK_KHZ * 1000) / (PWM_HZ * (1 << PWM_B));
    localparam int PER     = SD * (1 << PWM_B);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst      = 1'b1;
    logic             cfg_we   = 1'b0;
    logic [1:0]       cfg_ch   = 2'd0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [PWM_B-1:0] cfg_duty = '0;
    logic             sync     = 1'b0;
    logic [NCH-1:0]   led_a;
    logic             wrap_a;
    logic [NCH_B-1:0] led_b;
    logic             wrap_b;

    led_pattern_gen #(.CLK_FREQ_KHz(CLK_KHZ), .LED_FREQ_Hz(LED_HZ), .CHANNELS(NCH),
                      .PWM_BITS(PWM_B), .PWM_FREQ_Hz(PWM_HZ)) u_dut_a (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .sync(sync), .led(led_a), .pwm_wrap(wrap_a));

    led_pattern_gen #(.CLK_FREQ_KHz(CLK_KHZ), .LED_FREQ_Hz(LED_HZ), .CHANNELS(NCH_B),
                      .PWM_BITS(PWM_B), .PWM_FREQ_Hz(PWM_HZ)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_duty(cfg_duty), .sync(sync), .led(led_b), .pwm_wrap(wrap_b));

    int checks = 0;
    int errors = 0;

    // Reference model: n = cycles since the timebases last restarted.
    int n = 0;
    int m_mode[NCH];
    int m_pend[NCH];
    int m_act[NCH];
    int mb_mode[NCH_B];
    int mb_pend[NCH_B];
    int mb_act[NCH_B];
    logic [NCH-1:0]   exp_led   = '1;
    logic [NCH_B-1:0] exp_led_b = '1;
    logic             exp_wrap  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic out_bit(input int mode, input int duty, input int cyc);
        case (mode)
            1:       return 1'b1;
            2:       return ((cyc / HP) % 2) == 0;
            3:       return ((cyc / SD) % (1 << PWM_B)) < duty;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit boundary;
        if (rst) begin
            n = 0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 2; m_pend[i] = 0; m_act[i] = 0;
            end
            for (int i = 0; i < NCH_B; i++) begin
                mb_mode[i] = 2; mb_pend[i] = 0; mb_act[i] = 0;
            end
            exp_led   = '1;
            exp_led_b = '1;
            exp_wrap  = 1'b0;
        end else begin
            boundary = ((n + 1) % PER) == 0;
            for (int i = 0; i < NCH; i++)   exp_led[i]   = out_bit(m_mode[i], m_act[i], n);
            for (int i = 0; i < NCH_B; i++) exp_led_b[i] = out_bit(mb_mode[i], mb_act[i], n);
            exp_wrap = !sync && boundary;
            if (sync || boundary) begin
                for (int i = 0; i < NCH; i++)   m_act[i]  = m_pend[i];
                for (int i = 0; i < NCH_B; i++) mb_act[i] = mb_pend[i];
            end
            if (cfg_we) begin
                if (int'(cfg_ch) < NCH) begin
                    m_mode[cfg_ch] = int'(cfg_mode);
                    m_pend[cfg_ch] = int'(cfg_duty);
                end
                if (int'(cfg_ch) < NCH_B) begin
                    mb_mode[cfg_ch] = int'(cfg_mode);
                    mb_pend[cfg_ch] = int'(cfg_duty);
                end
            end
            n = sync ? 0 : n + 1;
        end
    endtask

    task automatic tick();
        if (rst || cfg_we || sync)
            $display("TXN t=%0t rst=%0b sync=%0b we=%0b ch=%0d mode=%0d duty=%0d",
                     $time, rst, sync, cfg_we, cfg_ch, cfg_mode, cfg_duty);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("led_a", led_a, exp_led);
        check("wrap_a", wrap_a, exp_wrap);
        check("led_b", led_b, exp_led_b);
        check("wrap_b", wrap_b, exp_wrap);
    endtask

    task automatic write(input int ch, input int mode, input int duty);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_mode = 2'(mode);
        cfg_duty = PWM_B'(duty);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic wait_wrap();
        bit seen = 0;
        for (int i = 0; i < 3 * PER && !seen; i++) begin
            tick();
            seen = wrap_a;
        end
        check("wrap_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int cnt;
        // reset
        tick();
        tick();
        check("rst_led", led_a, 4'hF);
        rst = 1'b0;

        // idle blink: 1111 for cycles 1-5, 0000 for 6-10, 1111 for 11-15
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3)  check("blink_hi1", led_a, 4'hF);
            if (k == 8)  check("blink_lo",  led_a, 4'h0);
            if (k == 13) check("blink_hi2", led_a, 4'hF);
        end

        // ch1 OFF, ch2 ON
        write(1, 0, 0);
        write(2, 1, 0);
        idle(12);
        check("ch1_off", 32'(led_a[1]), 32'd0);
        check("ch2_on",  32'(led_a[2]), 32'd1);

        // ch0 PWM duty 1, then rewrite duty 3 mid-period
        write(0, 3, 1);
        wait_wrap();
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            if (i == 3) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd3; cfg_duty = 2'd3;
            end
            tick();
            cfg_we = 1'b0;
            cnt += int'(led_a[0]);
        end
        check("pwm_duty1", 32'(cnt), 32'd2);
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            tick();
            cnt += int'(led_a[0]);
        end
        check("pwm_duty3", 32'(cnt), 32'd6);

        // ch3 PWM duty 0 stays dark; ch3 is out of range for the 3-channel instance
        write(3, 3, 0);
        idle(2 * PER);
        check("duty0", 32'(led_a[3]), 32'd0);
        write(3, 1, 2);
        idle(6);

        // sync mid-blink (blink_cnt=3, phase=0) with pending duty and a same-cycle write
        write(0, 3, 1);
        for (int i = 0; i < 2 * HP && (n % (2 * HP)) != HP + 3; i++) tick();
        check("sync_align", 32'(n % (2 * HP)), 32'(HP + 3));
        sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd3; cfg_duty = 2'd3;
        tick();
        sync = 1'b0;
        cfg_we = 1'b0;
        check("sync_nowrap", 32'(wrap_a), 32'd0);
        idle(2 * PER + 4);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            cfg_we   = ($urandom_range(0, 9) < 2);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_duty = PWM_B'($urandom_range(0, (1 << PWM_B) - 1));
            sync     = ($urandom_range(0, 59) == 0);
            rst      = ($urandom_range(0, 249) == 0);
            tick();
        end
        cfg_we = 1'b0; sync = 1'b0; rst = 1'b0;
        idle(4);

        // rst while PWM is active and a write is presented
        write(0, 3, 2);
        idle(5);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd3; cfg_duty = 2'd3;
        tick();
        check("rst_mid", led_a, 4'hF);
        rst = 1'b0;
        cfg_we = 1'b0;
        idle(2 * HP + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
